// File: rtl/ev_slot_scheduler.sv
// Round-robin charging-slot scheduler: per-requester session FSMs share NUM_SLOTS slots.
// Optional grant/abort statistics counters are built when EV_STATS_EN is defined.
module ev_slot_scheduler #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned MAX_TIME  = 200
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     done,
    input  logic [NUM_SLOTS-1:0]   slot_fault,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     active,
    output logic [3:0]             grant_slot,
    output logic [4*NUM_REQ-1:0]   req_slot,
    output logic [NUM_SLOTS-1:0]   slot_busy,
    output logic [NUM_REQ-1:0]     abort,
    output logic [3:0]             free_count,
    output logic [15:0]            grant_count,
    output logic [15:0]            abort_count
);
    localparam int unsigned PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] TMAX = 16'(MAX_TIME - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHARGING, S_LOCKOUT} state_t;

    state_t               r_state     [NUM_REQ];
    state_t               w_state_nxt [NUM_REQ];
    logic [3:0]           r_slot      [NUM_REQ];
    logic [15:0]          r_timer     [NUM_REQ];
    logic [PW-1:0]        r_rr;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_abort;
    logic [3:0]           r_grant_slot;
    logic [3:0]           r_free_count;
    logic [NUM_SLOTS-1:0] r_busy;

    logic                 w_win_vld;
    logic [PW-1:0]        w_win;
    logic [PW-1:0]        w_rr_nxt;
    logic                 w_slot_vld;
    logic [3:0]           w_free_slot;
    logic                 w_do_grant;
    logic [NUM_REQ-1:0]   w_held_fault;
    logic [NUM_REQ-1:0]   w_leave;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [NUM_REQ-1:0]   w_abort_nxt;
    logic [NUM_SLOTS-1:0] w_busy_nxt;
    logic [3:0]           w_free_nxt;

    // A WAIT requester whose req has just dropped is not granted; it returns to IDLE instead.
    always_comb begin
        w_win_vld = 1'b0;
        w_win     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_win_vld && r_state[PW'((32'(r_rr) + k) % NUM_REQ)] == S_WAIT
                && req[PW'((32'(r_rr) + k) % NUM_REQ)]) begin
                w_win_vld = 1'b1;
                w_win     = PW'((32'(r_rr) + k) % NUM_REQ);
            end
        end
        w_rr_nxt = (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + PW'(1);
    end

    always_comb begin
        w_slot_vld  = 1'b0;
        w_free_slot = 4'hF;
        for (int unsigned j = 0; j < NUM_SLOTS; j++) begin
            if (!w_slot_vld && !r_busy[j] && !slot_fault[j]) begin
                w_slot_vld  = 1'b1;
                w_free_slot = 4'(j);
            end
        end
        w_do_grant = w_win_vld && w_slot_vld;
    end

    always_comb begin
        w_held_fault = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            for (int unsigned j = 0; j < NUM_SLOTS; j++) begin
                if (r_slot[i] == 4'(j) && slot_fault[j]) w_held_fault[i] = 1'b1;
            end
        end
    end

    // Release (done or req drop) takes priority over timeout/fault, so it never aborts.
    always_comb begin
        w_grant_nxt = '0;
        w_abort_nxt = '0;
        w_leave     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                S_IDLE: if (req[i]) w_state_nxt[i] = S_WAIT;
                S_WAIT: begin
                    if (!req[i]) begin
                        w_state_nxt[i] = S_IDLE;
                    end else if (w_do_grant && w_win == PW'(i)) begin
                        w_state_nxt[i] = S_CHARGING;
                        w_grant_nxt[i] = 1'b1;
                    end
                end
                S_CHARGING: begin
                    if (done[i] || !req[i]) begin
                        w_state_nxt[i] = S_IDLE;
                        w_leave[i]     = 1'b1;
                    end else if (r_timer[i] == TMAX || w_held_fault[i]) begin
                        w_state_nxt[i] = S_LOCKOUT;
                        w_leave[i]     = 1'b1;
                        w_abort_nxt[i] = 1'b1;
                    end
                end
                S_LOCKOUT: if (!req[i]) w_state_nxt[i] = S_IDLE;
                default:   w_state_nxt[i] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy_nxt = r_busy;
        w_free_nxt = '0;
        for (int unsigned j = 0; j < NUM_SLOTS; j++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (w_leave[i] && r_slot[i] == 4'(j)) w_busy_nxt[j] = 1'b0;
            end
            if (w_do_grant && w_free_slot == 4'(j)) w_busy_nxt[j] = 1'b1;
            if (!w_busy_nxt[j] && !slot_fault[j]) w_free_nxt = w_free_nxt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_state[i] <= S_IDLE;
                r_slot[i]  <= 4'hF;
                r_timer[i] <= '0;
            end
            r_rr         <= '0;
            r_grant      <= '0;
            r_abort      <= '0;
            r_grant_slot <= 4'hF;
            r_busy       <= '0;
            r_free_count <= 4'(NUM_SLOTS);
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_state[i] <= w_state_nxt[i];
                if (w_grant_nxt[i]) begin
                    r_slot[i]  <= w_free_slot;
                    r_timer[i] <= '0;
                end else if (r_state[i] == S_CHARGING) begin
                    r_timer[i] <= r_timer[i] + 16'd1;
                end
            end
            if (w_do_grant) r_rr <= w_rr_nxt;
            r_grant_slot <= w_do_grant ? w_free_slot : 4'hF;
            r_grant      <= w_grant_nxt;
            r_abort      <= w_abort_nxt;
            r_busy       <= w_busy_nxt;
            r_free_count <= w_free_nxt;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            active[i]          = (r_state[i] == S_CHARGING);
            req_slot[4*i +: 4] = (r_state[i] == S_CHARGING) ? r_slot[i] : 4'hF;
        end
    end

    assign grant      = r_grant;
    assign abort      = r_abort;
    assign grant_slot = r_grant_slot;
    assign slot_busy  = r_busy;
    assign free_count = r_free_count;

`ifdef EV_STATS_EN
    logic [15:0] r_grant_count;
    logic [15:0] r_abort_count;
    logic [3:0]  w_abort_pop;
    logic [16:0] w_abort_sum;

    always_comb begin
        w_abort_pop = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_abort_nxt[i]) w_abort_pop = w_abort_pop + 4'd1;
        end
        w_abort_sum = {1'b0, r_abort_count} + 17'(w_abort_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_count <= '0;
            r_abort_count <= '0;
        end else begin
            if (w_do_grant && r_grant_count != 16'hFFFF) r_grant_count <= r_grant_count + 16'd1;
            r_abort_count <= w_abort_sum[16] ? 16'hFFFF : w_abort_sum[15:0];
        end
    end

    assign grant_count = r_grant_count;
    assign abort_count = r_abort_count;
`else
    assign grant_count = '0;
    assign abort_count = '0;
`endif

endmodule

// File: tb/tb_ev_slot_scheduler.sv
// Self-checking bench for ev_slot_scheduler: directed vector table, timeout sequence,
// and randomized traffic against a slot-ownership reference model.
`timescale 1ns/1ps
module tb_ev_slot_scheduler;
    localparam int NR = 4;
    localparam int NS = 4;
    localparam int MT = 200;

    logic            clk;
    logic            reset;
    logic [NR-1:0]   req, done, grant, active, abort;
    logic [NS-1:0]   slot_fault, slot_busy;
    logic [3:0]      grant_slot, free_count;
    logic [4*NR-1:0] req_slot;
    logic [15:0]     grant_count, abort_count;

    int checks = 0;
    int errors = 0;
    int exp_gcnt = 0;
    int exp_acnt = 0;

    ev_slot_scheduler #(.NUM_REQ(NR), .NUM_SLOTS(NS), .MAX_TIME(MT)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done), .slot_fault(slot_fault),
        .grant(grant), .active(active), .grant_slot(grant_slot), .req_slot(req_slot),
        .slot_busy(slot_busy), .abort(abort), .free_count(free_count),
        .grant_count(grant_count), .abort_count(abort_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pop4(input logic [3:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
    endfunction

    task automatic check_stats(input string tag);
`ifdef EV_STATS_EN
        check({tag, ".grant_count"}, 32'(grant_count), 32'(exp_gcnt > 65535 ? 65535 : exp_gcnt));
        check({tag, ".abort_count"}, 32'(abort_count), 32'(exp_acnt > 65535 ? 65535 : exp_acnt));
`else
        check({tag, ".grant_count"}, 32'(grant_count), 32'(0));
        check({tag, ".abort_count"}, 32'(abort_count), 32'(0));
`endif
    endtask

    // Reference model: who owns each slot, who waits, who is locked out, session age.
    int            m_holder [NS];
    bit            m_wait   [NR];
    bit            m_lock   [NR];
    int            m_age    [NR];
    int            m_rr;
    logic [NS-1:0] m_ft;
    logic [NR-1:0] e_grant, e_abort;
    logic [3:0]    e_gslot;

    function automatic int m_holds(input int r);
        for (int s = 0; s < NS; s++) if (m_holder[s] == r) return s;
        return -1;
    endfunction

    function automatic void m_reset();
        for (int s = 0; s < NS; s++) m_holder[s] = -1;
        for (int r = 0; r < NR; r++) begin
            m_wait[r] = 0; m_lock[r] = 0; m_age[r] = 0;
        end
        m_rr = 0; m_ft = '0; e_grant = '0; e_abort = '0; e_gslot = 4'hF;
        exp_gcnt = 0; exp_acnt = 0;
    endfunction

    function automatic void m_step(input logic [NR-1:0] rq, input logic [NR-1:0] dn,
                                   input logic [NS-1:0] ft);
        int win = -1;
        int fs = -1;
        bit g;
        bit was_idle [NR];
        for (int k = 0; k < NR; k++)
            if (win < 0 && m_wait[(m_rr + k) % NR] && rq[(m_rr + k) % NR]) win = (m_rr + k) % NR;
        for (int s = 0; s < NS; s++)
            if (fs < 0 && m_holder[s] < 0 && !ft[s]) fs = s;
        for (int r = 0; r < NR; r++) was_idle[r] = !m_wait[r] && !m_lock[r] && m_holds(r) < 0;
        g = (win >= 0) && (fs >= 0);
        e_grant = '0; e_abort = '0; e_gslot = 4'hF; m_ft = ft;
        for (int r = 0; r < NR; r++) if (m_lock[r] && !rq[r]) m_lock[r] = 0;
        for (int s = 0; s < NS; s++) begin
            if (m_holder[s] >= 0) begin
                int r;
                r = m_holder[s];
                if (dn[r] || !rq[r]) begin
                    m_holder[s] = -1;
                end else if (m_age[r] == MT || ft[s]) begin
                    m_holder[s] = -1; m_lock[r] = 1; e_abort[r] = 1'b1;
                end else begin
                    m_age[r]++;
                end
            end
        end
        for (int r = 0; r < NR; r++)
            m_wait[r] = m_wait[r] ? (rq[r] && !(g && r == win)) : (was_idle[r] && rq[r]);
        if (g) begin
            m_holder[fs] = win; m_age[win] = 1; m_rr = (win + 1) % NR;
            e_grant[win] = 1'b1; e_gslot = 4'(fs);
        end
        exp_gcnt += int'(g);
        exp_acnt += pop4(e_abort);
    endfunction

    task automatic cmp_model();
        logic [NR-1:0]   ea;
        logic [4*NR-1:0] ers;
        logic [NS-1:0]   eb;
        int              ef;
        ef = 0;
        for (int r = 0; r < NR; r++) begin
            ea[r] = m_holds(r) >= 0;
            ers[4*r +: 4] = ea[r] ? 4'(m_holds(r)) : 4'hF;
        end
        for (int s = 0; s < NS; s++) begin
            eb[s] = m_holder[s] >= 0;
            if (!eb[s] && !m_ft[s]) ef++;
        end
        check("rnd.grant", 32'(grant), 32'(e_grant));
        check("rnd.grant_slot", 32'(grant_slot), 32'(e_gslot));
        check("rnd.abort", 32'(abort), 32'(e_abort));
        check("rnd.active", 32'(active), 32'(ea));
        check("rnd.req_slot", 32'(req_slot), 32'(ers));
        check("rnd.slot_busy", 32'(slot_busy), 32'(eb));
        check("rnd.free_count", 32'(free_count), 32'(ef));
        check_stats("rnd");
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; done = '0; slot_fault = '0;
        tick();
        reset = 1'b0;
        m_reset();
        check("rst.grant", 32'(grant), 32'(0));
        check("rst.active", 32'(active), 32'(0));
        check("rst.abort", 32'(abort), 32'(0));
        check("rst.grant_slot", 32'(grant_slot), 32'(4'hF));
        check("rst.req_slot", 32'(req_slot), 32'(16'hFFFF));
        check("rst.slot_busy", 32'(slot_busy), 32'(0));
        check("rst.free_count", 32'(free_count), 32'(NS));
        check_stats("rst");
    endtask

    typedef struct {
        logic [3:0]  rq, dn, ft, g, act, gs, busy, ab, fr;
        logic [15:0] rs;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] rq, dn, ft, g, act, gs, busy, ab, fr,
                                input logic [15:0] rs);
        vec_t v;
        v.rq = rq; v.dn = dn; v.ft = ft; v.g = g; v.act = act; v.gs = gs;
        v.busy = busy; v.ab = ab; v.fr = fr; v.rs = rs;
        return v;
    endfunction

    vec_t tbl [21];

    initial begin
        int first_abort;
        reset = 1'b1; req = '0; done = '0; slot_fault = '0;

        //            rq    dn    ft    grant act  gslot busy abort free req_slot
        tbl[0]  = mk(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'd4, 16'hFFFF);
        tbl[1]  = mk(4'hF, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 4'd3, 16'hFFF0);
        tbl[2]  = mk(4'hF, 4'h0, 4'h0, 4'h2, 4'h3, 4'h1, 4'h3, 4'h0, 4'd2, 16'hFF10);
        tbl[3]  = mk(4'hF, 4'h0, 4'h0, 4'h4, 4'h7, 4'h2, 4'h7, 4'h0, 4'd1, 16'hF210);
        tbl[4]  = mk(4'hF, 4'h0, 4'h0, 4'h8, 4'hF, 4'h3, 4'hF, 4'h0, 4'd0, 16'h3210);
        tbl[5]  = mk(4'hF, 4'h2, 4'h0, 4'h0, 4'hD, 4'hF, 4'hD, 4'h0, 4'd1, 16'h32F0);
        tbl[6]  = mk(4'hF, 4'h0, 4'h0, 4'h0, 4'hD, 4'hF, 4'hD, 4'h0, 4'd1, 16'h32F0);
        tbl[7]  = mk(4'hF, 4'h0, 4'h0, 4'h2, 4'hF, 4'h1, 4'hF, 4'h0, 4'd0, 16'h3210);
        tbl[8]  = mk(4'hA, 4'h0, 4'h0, 4'h0, 4'hA, 4'hF, 4'hA, 4'h0, 4'd2, 16'h3F1F);
        tbl[9]  = mk(4'hF, 4'h0, 4'h5, 4'h0, 4'hA, 4'hF, 4'hA, 4'h0, 4'd0, 16'h3F1F);
        tbl[10] = mk(4'hF, 4'h0, 4'h5, 4'h0, 4'hA, 4'hF, 4'hA, 4'h0, 4'd0, 16'h3F1F);
        tbl[11] = mk(4'hF, 4'h8, 4'h5, 4'h0, 4'h2, 4'hF, 4'h2, 4'h0, 4'd1, 16'hFF1F);
        tbl[12] = mk(4'hF, 4'h0, 4'h5, 4'h4, 4'h6, 4'h3, 4'hA, 4'h0, 4'd0, 16'hF31F);
        tbl[13] = mk(4'hF, 4'h0, 4'h5, 4'h0, 4'h6, 4'hF, 4'hA, 4'h0, 4'd0, 16'hF31F);
        tbl[14] = mk(4'hF, 4'h0, 4'h8, 4'h8, 4'hA, 4'h0, 4'h3, 4'h4, 4'd1, 16'h0F1F);
        tbl[15] = mk(4'hF, 4'h0, 4'h8, 4'h1, 4'hB, 4'h2, 4'h7, 4'h0, 4'd0, 16'h0F12);
        tbl[16] = mk(4'hF, 4'h0, 4'h8, 4'h0, 4'hB, 4'hF, 4'h7, 4'h0, 4'd0, 16'h0F12);
        tbl[17] = mk(4'hB, 4'h0, 4'h8, 4'h0, 4'hB, 4'hF, 4'h7, 4'h0, 4'd0, 16'h0F12);
        tbl[18] = mk(4'hF, 4'h0, 4'h8, 4'h0, 4'hB, 4'hF, 4'h7, 4'h0, 4'd0, 16'h0F12);
        tbl[19] = mk(4'hF, 4'h0, 4'h8, 4'h0, 4'hB, 4'hF, 4'h7, 4'h0, 4'd0, 16'h0F12);
        tbl[20] = mk(4'hF, 4'h0, 4'h0, 4'h4, 4'hF, 4'h3, 4'hF, 4'h0, 4'd0, 16'h0312);

        tick(); tick();
        do_reset();

        for (int i = 0; i < 21; i++) begin
            req = tbl[i].rq; done = tbl[i].dn; slot_fault = tbl[i].ft;
            tick();
            exp_gcnt += pop4(tbl[i].g);
            exp_acnt += pop4(tbl[i].ab);
            check($sformatf("tbl%0d.grant", i), 32'(grant), 32'(tbl[i].g));
            check($sformatf("tbl%0d.active", i), 32'(active), 32'(tbl[i].act));
            check($sformatf("tbl%0d.grant_slot", i), 32'(grant_slot), 32'(tbl[i].gs));
            check($sformatf("tbl%0d.slot_busy", i), 32'(slot_busy), 32'(tbl[i].busy));
            check($sformatf("tbl%0d.abort", i), 32'(abort), 32'(tbl[i].ab));
            check($sformatf("tbl%0d.free_count", i), 32'(free_count), 32'(tbl[i].fr));
            check($sformatf("tbl%0d.req_slot", i), 32'(req_slot), 32'(tbl[i].rs));
            check_stats($sformatf("tbl%0d", i));
        end

        // Session timeout: abort on the MT-th edge after the grant, then lockout until req drops.
        do_reset();
        req = 4'b0001;
        tick();
        check("to.wait_no_grant", 32'(grant), 32'(0));
        tick();
        check("to.grant", 32'(grant), 32'(4'b0001));
        first_abort = -1;
        for (int k = 1; k <= MT + 5; k++) begin
            tick();
            if (first_abort < 0 && abort != '0) begin
                first_abort = k;
                check("to.abort_vec", 32'(abort), 32'(4'b0001));
                check("to.active_after", 32'(active), 32'(0));
                check("to.busy_after", 32'(slot_busy), 32'(0));
            end
        end
        check("to.abort_cycle", 32'(first_abort), 32'(MT));
        for (int k = 0; k < 4; k++) begin
            tick();
            check("to.lockout_no_grant", 32'({grant, active}), 32'(0));
        end
        req = 4'b0000; tick();
        req = 4'b0001; tick();
        check("to.rereq_wait", 32'(grant), 32'(0));
        tick();
        check("to.regrant", 32'(grant), 32'(4'b0001));
        check("to.regrant_slot", 32'(grant_slot), 32'(0));

        // Random traffic with occasional faults and mid-session resets.
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            for (int r = 0; r < NR; r++) if ($urandom_range(0, 7) == 0) req[r] = ~req[r];
            done = '0;
            for (int r = 0; r < NR; r++) if ($urandom_range(0, 9) == 0) done[r] = 1'b1;
            for (int s = 0; s < NS; s++)
                if (slot_fault[s] ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 199) == 0))
                    slot_fault[s] = ~slot_fault[s];
            reset = ($urandom_range(0, 399) == 0);
            tick();
            if (reset) m_reset(); else m_step(req, done, slot_fault);
            cmp_model();
        end
        reset = 1'b0;

        // Long sessions so that timeouts occur under contention.
        done = '0; slot_fault = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int r = 0; r < NR; r++) if ($urandom_range(0, 299) == 0) req[r] = ~req[r];
            tick();
            m_step(req, done, slot_fault);
            cmp_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
